dqs_seq_ds: RTL and testbench
=============================

// Module: dqs_seq_ds
// PURPOSE
//  Multi-lane DDR strobe generator: drives LANES differential tristatable strobes (ODDR + OBUFTDS per lane)
//  with a sequenced preamble / toggling burst / postamble and automatic tristate control.
//  Sits in the write path of the DDR3 PHY, one instance per byte-group set, under the write sequencer.
//  Supersedes single-lane fixed-mode DDR output wrappers: adds burst sequencing, back-to-back merge, lane masking.
// PARAMETERS
//  LANES        2              number of differential strobe lanes
//  LEN_W        4              width of burst length input (clock cycles of toggling, 1..2^LEN_W-1)
//  PREAMBLE     1              cycles driven low before first toggle (1..3)
//  POSTAMBLE    1              cycles driven low after last toggle (1..3)
//  IOSTANDARD   "DIFF_SSTL15"  pad standard, passed to OBUFTDS
//  SLEW         "SLOW"         pad slew, passed to OBUFTDS
// PORTS
//  clk      in   1        PHY clock; ODDR clock, SAME_EDGE mode
//  rst_n    in   1        asynchronous active-low reset
//  start    in   1        request a burst; accepted only when ready=1
//  len      in   LEN_W    burst length in clk cycles, sampled with accepted start
//  lane_en  in   LANES    lane mask, sampled with accepted start from IDLE; 0 = lane stays Hi-Z
//  ready    out  1        start will be accepted this cycle
//  busy     out  1        state != IDLE
//  done     out  1        one-cycle pulse on the last POSTAMBLE cycle
//  err      out  1        one-cycle pulse: start refused (ready=0 or len=0)
//  dqs      out  LANES    differential strobe, positive legs
//  ndqs     out  LANES    differential strobe, negative legs
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, counters 0, busy=0, done=0, err=0, ready=1, lane mask register 0,
//    per-lane din register 2'b00, per-lane T register 1 (Hi-Z asserted immediately, no clock needed).
//  - FSM: IDLE -> PRE (PREAMBLE cycles) -> BURST (len cycles) -> POST (POSTAMBLE cycles) -> IDLE.
//  - Accepted start in IDLE (len!=0): next edge enters PRE, cnt=PREAMBLE, len latched, lane mask latched.
//  - Per-lane drive (enabled lanes): PRE din=2'b00,T=0; BURST din=2'b01 (D1=1 high half, D2=0), T=0;
//    POST din=2'b00,T=0; IDLE T=1. Disabled lanes: T=1 in all states.
//  - din/T are registered in fabric, then ODDR adds one more clk: pad follows state with 2-cycle latency.
//  - ready = IDLE, or BURST with cnt==1, or POST (any cycle).
//  - Back-to-back merge: accepted start in BURST cnt==1 or in POST -> next state BURST, cnt=new len,
//    no preamble inserted, strobe toggles continuously; lane mask NOT reloaded (lanes fixed for the merged train).
//  - start with ready=0, or len=0 in any state: ignored, err=1 for one cycle; FSM unaffected.
//  - done pulses only when leaving POST to IDLE; not on merged restarts.
//  - Counter width max(LEN_W,2); len latched as-is, no wrap (len=2^LEN_W-1 is the max legal value).
//  - Reset asserted mid-burst: pads go Hi-Z asynchronously via T register; ODDR data left as is (don't care).
//  - ODDR R/S tied 0, CE tied 1; tristate uses T register directly (no ODDR on T path).
// STRUCTURE
//  - Package ddr_phy_pkg: typedef enum {IDLE,PRE,BURST,POST} dqs_state_t; din encodings DQS_LOW=2'b00,
//    DQS_TOGGLE=2'b01; localparam limits for PREAMBLE/POSTAMBLE.
//  - Sub-module dqs_lane_out: one lane = ODDR + OBUFTDS, generated LANES times; FSM/counters in top.
// TESTING
//  - Reset: rst_n=0 then 1, no start -> dqs/ndqs Hi-Z on all lanes, ready=1, busy=0, done=err=0.
//  - Single burst: start=1,len=4,lane_en=2'b11 -> 1 low, 4 toggle cycles, 1 low, then Hi-Z; done at cycle 6, busy 6 cycles.
//  - Back-to-back: len=4 then start on BURST cnt==1 with len=2 -> 6 contiguous toggles, one preamble, one done.
//  - Refusal: start during PRE, and start with len=0 in IDLE -> err=1 one cycle each, waveform unchanged.
//  - Lane mask: lane_en=2'b10, len=3 -> lane1 toggles 3 cycles, lane0 Hi-Z throughout; mask change mid-burst ignored.
//  - Async reset mid-burst at cycle 3 of len=8 -> T=1 same instant (before next clk), busy=0, ready=1, no done.

Source files
------------

// File: rtl/ddr_phy_pkg.sv
// ddr_phy_pkg
//   Shared types and constants for the DDR3 PHY write-strobe path.
//   dqs_state_t : strobe sequencer states
//   DQS_LOW     : ODDR {D2,D1} pattern for a strobe held low for a full cycle
//   DQS_TOGGLE  : ODDR {D2,D1} pattern for one strobe period (high half, then low half)
//   AMBLE_MIN/MAX : legal range for preamble/postamble lengths
package ddr_phy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    BURST = 2'd2,
    POST  = 2'd3
  } dqs_state_t;

  localparam logic [1:0] DQS_LOW    = 2'b00;
  localparam logic [1:0] DQS_TOGGLE = 2'b01;

  localparam int AMBLE_MIN = 1;
  localparam int AMBLE_MAX = 3;

  // The counter has to hold both len and the amble lengths (up to 3).
  function automatic int cnt_width(input int len_w);
    return (len_w > 2) ? len_w : 2;
  endfunction

endpackage

// File: rtl/dqs_lane_out.sv
// dqs_lane_out
//   One differential strobe lane: same-edge DDR output register feeding a
//   tristatable differential pad driver.
//   clk   : PHY clock, DDR output clock
//   rst_n : async active-low reset, forces the pad to Hi-Z immediately
//   din   : {D2,D1}; D1 is driven during the high half of clk, D2 during the low half
//   t     : tristate request from the sequencer, 1 = Hi-Z
//   dqs   : positive pad leg
//   ndqs  : negative pad leg
module dqs_lane_out
  import ddr_phy_pkg::*;
#(
  parameter IOSTANDARD = "DIFF_SSTL15",
  parameter SLEW       = "SLOW"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  input  logic       t,
  output tri         dqs,
  output tri         ndqs
);

  if (SLEW != "SLOW" && SLEW != "FAST") begin : g_bad_slew
    $error("dqs_lane_out: SLEW must be SLOW or FAST");
  end
  if (IOSTANDARD == "") begin : g_bad_iostd
    $error("dqs_lane_out: IOSTANDARD must name a differential pad standard");
  end

  logic d1_q;
  logic d2_q;
  logic t_q;
  logic oddr_q;

  // Output DDR register: no reset or set, clock enable always on.
  always_ff @(posedge clk) begin
    d1_q <= din[0];
    d2_q <= din[1];
  end

  // Tristate stage is clocked alongside the data stage so enable and data
  // reach the pad on the same edge; its reset gives Hi-Z without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= 1'b1;
    end else begin
      t_q <= t;
    end
  end

  assign oddr_q = clk ? d1_q : d2_q;

  assign dqs  = t_q ? 1'bz : oddr_q;
  assign ndqs = t_q ? 1'bz : ~oddr_q;

endmodule

// File: rtl/dqs_seq_ds.sv
// dqs_seq_ds
//   Multi-lane DDR write-strobe sequencer: preamble, toggling burst and
//   postamble with automatic tristate, back-to-back merge and lane masking.
//   clk     : PHY clock
//   rst_n   : async active-low reset
//   start   : burst request, taken only while ready=1 and len!=0
//   len     : burst length in clk cycles, sampled with an accepted start
//   lane_en : lane mask, sampled with a start accepted from IDLE
//   ready   : a start presented now will be accepted
//   busy    : sequencer not idle
//   done    : one-cycle pulse in the final postamble cycle
//   err     : one-cycle pulse after a refused start
//   dqs     : strobe positive legs, one per lane
//   ndqs    : strobe negative legs, one per lane
//
//   state | meaning
//   IDLE  | pads Hi-Z, waiting for start
//   PRE   | strobe driven low before the first toggle
//   BURST | strobe toggles once per clk
//   POST  | strobe driven low after the last toggle
module dqs_seq_ds
  import ddr_phy_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int LEN_W      = 4,
  parameter int PREAMBLE   = 1,
  parameter int POSTAMBLE  = 1,
  parameter     IOSTANDARD = "DIFF_SSTL15",
  parameter     SLEW       = "SLOW"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [LANES-1:0] lane_en,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output tri   [LANES-1:0] dqs,
  output tri   [LANES-1:0] ndqs
);

  if (PREAMBLE < AMBLE_MIN || PREAMBLE > AMBLE_MAX) begin : g_bad_pre
    $error("dqs_seq_ds: PREAMBLE out of range");
  end
  if (POSTAMBLE < AMBLE_MIN || POSTAMBLE > AMBLE_MAX) begin : g_bad_post
    $error("dqs_seq_ds: POSTAMBLE out of range");
  end

  localparam int CW = cnt_width(LEN_W);

  dqs_state_t             state;
  logic [CW-1:0]          cnt;
  logic [LEN_W-1:0]       len_r;
  logic [LANES-1:0]       mask_r;
  logic [LANES-1:0][1:0]  din_r;
  logic [LANES-1:0]       t_r;
  logic                   last;
  logic                   accept;

  assign last   = (cnt == CW'(1));
  assign ready  = (state == IDLE) || (state == BURST && last) || (state == POST);
  assign accept = start && ready && (len != '0);
  assign busy   = (state != IDLE);
  // A start taken in the final postamble cycle continues the train, so
  // that cycle is not an end of burst.
  assign done   = (state == POST) && last && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      len_r  <= '0;
      mask_r <= '0;
      err    <= 1'b0;
      din_r  <= '0;
      t_r    <= '1;
    end else begin
      err <= start && !accept;

      case (state)
        IDLE: begin
          if (accept) begin
            state  <= PRE;
            cnt    <= CW'(PREAMBLE);
            len_r  <= len;
            mask_r <= lane_en;
          end
        end
        PRE: begin
          if (last) begin
            state <= BURST;
            cnt   <= CW'(len_r);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BURST, POST: begin
          // Merge: the new burst follows with no preamble and keeps the
          // lane mask of the train already on the bus.
          if (accept) begin
            state <= BURST;
            cnt   <= CW'(len);
          end else if (last) begin
            if (state == BURST) begin
              state <= POST;
              cnt   <= CW'(POSTAMBLE);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      for (int i = 0; i < LANES; i++) begin
        din_r[i] <= (state == BURST) ? DQS_TOGGLE : DQS_LOW;
        t_r[i]   <= (state == IDLE) || !mask_r[i];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dqs_lane_out #(
      .IOSTANDARD (IOSTANDARD),
      .SLEW       (SLEW)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din_r[g]),
      .t    (t_r[g]),
      .dqs  (dqs[g]),
      .ndqs (ndqs[g])
    );
  end

endmodule

// File: tb/tb_dqs_seq_ds.sv
// tb_dqs_seq_ds
//   Bench for dqs_seq_ds. The reference model is a per-cycle timeline of
//   bus symbols ("I" idle, "P" preamble low, "T" toggle, "Q" postamble low)
//   plus the lane mask of each cycle. Undriven pads read back through
//   pulls: dqs pulled high, ndqs pulled low, which no driven strobe shows in
//   its low half-cycle.
module tb_dqs_seq_ds;

  localparam int LANES = 2;
  localparam int LEN_W = 4;
  localparam int PRE_N = 1;
  localparam int POST_N = 1;
  localparam int TL_N = 4096;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [LANES-1:0] lane_en = '0;
  logic             ready;
  logic             busy;
  logic             done;
  logic             err;
  tri1  [LANES-1:0] dqs_w;
  tri0  [LANES-1:0] ndqs_w;

  dqs_seq_ds #(
    .LANES     (LANES),
    .LEN_W     (LEN_W),
    .PREAMBLE  (PRE_N),
    .POSTAMBLE (POST_N),
    .IOSTANDARD("DIFF_SSTL15"),
    .SLEW      ("SLOW")
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .len    (len),
    .lane_en(lane_en),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .dqs    (dqs_w),
    .ndqs   (ndqs_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  byte        tl [TL_N];
  logic [1:0] mk [TL_N];

  typedef struct { int c; logic [7:0] v; } pad_t;
  typedef struct { int c; logic b; logic r; } stat_t;
  pad_t  pad_q[$];
  stat_t stat_q[$];
  int    done_q[$];
  int    err_q[$];
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input int exp_cyc);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d expected_at=%0d", name, cyc, exp_cyc);
  endtask

  // Pad image {dqs_hi, ndqs_hi, dqs_lo, ndqs_lo}, each LANES bits wide.
  function automatic logic [7:0] pad_exp(input byte s, input logic [1:0] m);
    logic [1:0] dh, nh, dl, nl;
    for (int i = 0; i < LANES; i++) begin
      if (!m[i] || s == "I")  {dh[i], nh[i], dl[i], nl[i]} = 4'b1010;
      else if (s == "T")      {dh[i], nh[i], dl[i], nl[i]} = 4'b1001;
      else                    {dh[i], nh[i], dl[i], nl[i]} = 4'b0101;
    end
    return {dh, nh, dl, nl};
  endfunction

  function automatic bit mdl_ready(input int m);
    return (tl[m] == "I") || (tl[m] == "Q") || (tl[m] == "T" && tl[m+1] != "T");
  endfunction

  // One clock of stimulus; the model is advanced with the same inputs.
  task automatic step(input bit s, input logic [LEN_W-1:0] l, input logic [1:0] e);
    int m;
    int k;
    bit acc;
    logic [1:0] mm;
    pad_t p;
    stat_t st;
    @(posedge clk);
    #1;
    m = cyc;
    p.c = m + 2;
    p.v = pad_exp(tl[m], mk[m]);
    pad_q.push_back(p);
    st.c = m;
    st.b = (tl[m] != "I");
    st.r = mdl_ready(m);
    stat_q.push_back(st);
    acc = s && mdl_ready(m) && (l != 0);
    if (s && !acc) err_q.push_back(m + 1);
    if (acc) begin
      mm = (tl[m] == "I") ? e : mk[m];
      k = m + 1;
      if (tl[m] == "I") begin
        for (int j = 0; j < PRE_N; j++) begin tl[k] = "P"; mk[k] = mm; k++; end
      end
      for (int j = 0; j < int'(l); j++) begin tl[k] = "T"; mk[k] = mm; k++; end
      for (int j = 0; j < POST_N; j++) begin tl[k] = "Q"; mk[k] = mm; k++; end
      for (int j = k; j < m + 40; j++) tl[j] = "I";
    end
    if (tl[m] == "Q" && tl[m+1] == "I") done_q.push_back(m);
    start = s;
    len = l;
    lane_en = e;
  endtask

  initial begin : monitor
    logic [1:0] hd, hn, ld, ln;
    pad_t p;
    stat_t s;
    forever begin
      @(posedge clk);
      #3;
      hd = dqs_w;
      hn = ndqs_w;
      @(negedge clk);
      #1;
      ld = dqs_w;
      ln = ndqs_w;
      if (mon_en) begin
        while (pad_q.size() > 0 && pad_q[0].c < cyc) void'(pad_q.pop_front());
        if (pad_q.size() > 0 && pad_q[0].c == cyc) begin
          p = pad_q.pop_front();
          chk("pads", {24'd0, hd, hn, ld, ln}, {24'd0, p.v});
        end
        while (stat_q.size() > 0 && stat_q[0].c < cyc) void'(stat_q.pop_front());
        if (stat_q.size() > 0 && stat_q[0].c == cyc) begin
          s = stat_q.pop_front();
          chk("busy", {31'd0, busy}, {31'd0, s.b});
          chk("ready", {31'd0, ready}, {31'd0, s.r});
        end
        if (done_q.size() > 0 && done_q[0] < cyc) fail_event("done_missing", done_q.pop_front());
        if (done) begin
          if (done_q.size() == 0) fail_event("done_unexpected", -1);
          else chk("done_cycle", cyc, done_q.pop_front());
        end
        if (err_q.size() > 0 && err_q[0] < cyc) fail_event("err_missing", err_q.pop_front());
        if (err) begin
          if (err_q.size() == 0) fail_event("err_unexpected", -1);
          else chk("err_cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < TL_N; i++) begin
      tl[i] = "I";
      mk[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dqs_hiz", {30'd0, dqs_w}, 32'd3);
    chk("rst_ndqs_hiz", {30'd0, ndqs_w}, 32'd0);
    mon_en = 1'b1;

    repeat (3) step(0, 0, 2'b00);
    // single burst
    step(1, 4, 2'b11);
    repeat (10) step(0, 0, 2'b00);
    // back-to-back merge on the last burst cycle
    step(1, 4, 2'b11);
    repeat (4) step(0, 0, 2'b11);
    step(1, 2, 2'b11);
    repeat (10) step(0, 0, 2'b00);
    // refusals: start during preamble, len=0 while idle
    step(1, 4, 2'b11);
    step(1, 5, 2'b11);
    repeat (8) step(0, 0, 2'b00);
    step(1, 0, 2'b11);
    repeat (3) step(0, 0, 2'b00);
    // lane mask, changed mid-burst
    step(1, 3, 2'b10);
    step(0, 0, 2'b01);
    step(0, 0, 2'b11);
    repeat (8) step(0, 0, 2'b01);
    // longest legal burst
    step(1, 15, 2'b11);
    repeat (20) step(0, 0, 2'b00);
    // random traffic
    repeat (400) begin
      step(($urandom_range(0, 2) == 0), LEN_W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    repeat (25) step(0, 0, 2'b00);

    // asynchronous reset in the third toggle cycle of a len=8 burst
    step(1, 8, 2'b11);
    repeat (4) step(0, 0, 2'b00);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    chk("pre_rst_dqs_driven", {30'd0, dqs_w}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_dqs_hiz", {30'd0, dqs_w}, 32'd3);
    chk("arst_ndqs_hiz", {30'd0, ndqs_w}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_done", {31'd0, done}, 32'd0);
    pad_q.delete();
    stat_q.delete();
    done_q.delete();
    err_q.delete();
    for (int j = cyc; j < cyc + 60; j++) tl[j] = "I";
    repeat (2) @(posedge clk);
    #3;
    chk("arst_hold_dqs_hiz", {30'd0, dqs_w}, 32'd3);
    chk("arst_hold_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) step(0, 0, 2'b00);
    step(1, 2, 2'b01);
    repeat (8) step(0, 0, 2'b00);

    repeat (3) @(posedge clk);
    chk("done_q_drained", done_q.size(), 32'd0);
    chk("err_q_drained", err_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
